// File: rtl/bank_enable_table_if.sv
`default_nettype none
// ============================================================================
// Module      : bank_enable_table_if
// Description : Host CPU bus bundle seen by the chip-select table
//               (address/phase/direction in, RAM select/bus enable out).
// Revision    : 1.0 - initial release
// ============================================================================
interface bank_enable_table_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  phi2;
  logic                  rwbar;
  logic                  mreq;
  logic                  cs_ram;
  logic                  cs_bus;
  logic                  we;

  modport master (
    output address, phi2, rwbar, mreq,
    input  cs_ram, cs_bus, we
  );

  modport slave (
    input  address, phi2, rwbar, mreq,
    output cs_ram, cs_bus, we
  );
endinterface
`default_nettype wire

// File: rtl/bank_enable_table.sv
`default_nettype none
// ============================================================================
// Module      : bank_enable_table
// Description : Banked per-region, per-direction RAM/bus chip-select table
//               with self-clear, glitch-free bank switching and region
//               disable. Optional write-protect fault capture: WP_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_enable_table #(
  parameter int ADDR_WIDTH  = 16,
  parameter int GRANULARITY = 256,
  parameter int NUM_BANKS   = 4
) (
  input  wire logic                                      fpga_clk,
  input  wire logic                                      rst_n,
  bank_enable_table_if.slave                             cpu,
  input  wire logic                                      table_we,
  input  wire logic [$clog2(NUM_BANKS)-1:0]              table_bank,
  input  wire logic [ADDR_WIDTH-$clog2(GRANULARITY):0]   table_write_addr,
  input  wire logic [1:0]                                table_val,
  output logic                                           table_rdy,
  input  wire logic                                      clear_req,
  input  wire logic                                      bank_req,
  input  wire logic [$clog2(NUM_BANKS)-1:0]              bank_sel,
  output logic                                           bank_ack,
  output logic [$clog2(NUM_BANKS)-1:0]                   active_bank,
`ifdef WP_FAULT_EN
  output logic                                           fault,
  output logic [ADDR_WIDTH-1:0]                          fault_addr,
  input  wire logic                                      fault_clr,
`endif
  input  wire logic                                      ram_disable,
  input  wire logic                                      rom_disable
);

  localparam int c_RB    = ADDR_WIDTH - $clog2(GRANULARITY);
  localparam int c_BB    = $clog2(NUM_BANKS);
  localparam int c_IW    = c_BB + 1 + c_RB;
  localparam int c_DEPTH = 2 ** c_IW;
  localparam logic [c_IW:0] c_CNT_ONE = {{c_IW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_IW:0]   r_clr_cnt;
  logic [1:0]      r_table [0:c_DEPTH-1];
  logic [1:0]      r_outval;
  logic            r_disable_region;
  logic [c_BB-1:0] r_active_bank;
  logic [c_BB-1:0] r_pend_bank;
  logic            r_pending;
  logic            r_bank_ack;

  logic [c_RB-1:0] w_region;
  logic [1:0]      w_lookup;
  logic [1:0]      w_wr_entry;
  logic [1:0]      w_rd_entry;
  logic            w_disable_next;

  assign w_region   = cpu.address[ADDR_WIDTH-1 -: c_RB];
  assign w_lookup   = r_table[{r_active_bank, cpu.rwbar, w_region}];
  assign w_wr_entry = r_table[{r_active_bank, 1'b0, w_region}];
  assign w_rd_entry = r_table[{r_active_bank, 1'b1, w_region}];

  // ROM-type region: readable RAM but not writable; RAM-type: both.
  assign w_disable_next = (rom_disable & ~w_wr_entry[1] & w_rd_entry[1])
                        | (ram_disable &  w_wr_entry[1] & w_rd_entry[1]);

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_CLEAR;
      r_clr_cnt        <= '0;
      r_outval         <= 2'b01;
      r_disable_region <= 1'b0;
      r_active_bank    <= '0;
      r_pend_bank      <= '0;
      r_pending        <= 1'b0;
      r_bank_ack       <= 1'b0;
    end else begin
      // Bank changes only land while phi2 is low, so a cycle never sees two maps.
      r_bank_ack <= 1'b0;
      if (r_pending && !cpu.phi2) begin
        r_active_bank <= r_pend_bank;
        r_pending     <= 1'b0;
        r_bank_ack    <= 1'b1;
      end
      if (bank_req) begin
        r_pend_bank <= bank_sel;
        r_pending   <= 1'b1;
      end

      if (clear_req) begin
        r_state          <= ST_CLEAR;
        r_clr_cnt        <= '0;
        r_outval         <= 2'b01;
        r_disable_region <= 1'b0;
      end else begin
        case (r_state)
          ST_CLEAR: begin
            r_outval         <= 2'b01;
            r_disable_region <= 1'b0;
            if (!r_clr_cnt[c_IW]) begin
              r_clr_cnt <= r_clr_cnt + c_CNT_ONE;
            end
            if (&r_clr_cnt[c_IW-1:0]) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_outval         <= w_lookup;
            r_disable_region <= w_disable_next;
          end
        endcase
      end
    end
  end

  // Table storage is rebuilt by the clear sweep, so it carries no reset.
  always_ff @(posedge fpga_clk) begin
    if (!clear_req) begin
      if (r_state == ST_CLEAR) begin
        r_table[r_clr_cnt[c_IW-1:0]] <= 2'b01;
      end else if (table_we) begin
        r_table[{table_bank, table_write_addr}] <= table_val;
      end
    end
  end

`ifdef WP_FAULT_EN
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_fault_addr;
  logic                  w_fault_hit;

  assign w_fault_hit = (r_state == ST_IDLE) & cpu.phi2 & ~cpu.rwbar & cpu.mreq
                     & (w_wr_entry == 2'b00);

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault_hit && (!r_fault || fault_clr)) begin
      r_fault      <= 1'b1;
      r_fault_addr <= cpu.address;
    end else if (fault_clr) begin
      r_fault <= 1'b0;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
`endif

  assign cpu.cs_ram  = cpu.phi2 & r_outval[1] & cpu.mreq & ~r_disable_region;
  assign cpu.cs_bus  = (cpu.phi2 & r_outval[0]) | ~cpu.mreq | r_disable_region;
  assign cpu.we      = cpu.phi2 & ~cpu.rwbar;
  assign table_rdy   = (r_state == ST_IDLE);
  assign bank_ack    = r_bank_ack;
  assign active_bank = r_active_bank;

endmodule
`default_nettype wire

// File: tb/tb_bank_enable_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_enable_table
// Description : Directed self-checking bench for bank_enable_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_enable_table;

  logic       fpga_clk = 1'b0;
  logic       rst_n;
  logic       table_we;
  logic [1:0] table_bank;
  logic [8:0] table_write_addr;
  logic [1:0] table_val;
  logic       table_rdy;
  logic       clear_req;
  logic       bank_req;
  logic [1:0] bank_sel;
  logic       bank_ack;
  logic [1:0] active_bank;
  logic       ram_disable;
  logic       rom_disable;
`ifdef WP_FAULT_EN
  logic        fault;
  logic [15:0] fault_addr;
  logic        fault_clr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bank_enable_table_if #(.ADDR_WIDTH(16)) cpu_bus ();

  bank_enable_table #(
    .ADDR_WIDTH(16), .GRANULARITY(256), .NUM_BANKS(4)
  ) dut (
    .fpga_clk        (fpga_clk),
    .rst_n           (rst_n),
    .cpu             (cpu_bus),
    .table_we        (table_we),
    .table_bank      (table_bank),
    .table_write_addr(table_write_addr),
    .table_val       (table_val),
    .table_rdy       (table_rdy),
    .clear_req       (clear_req),
    .bank_req        (bank_req),
    .bank_sel        (bank_sel),
    .bank_ack        (bank_ack),
    .active_bank     (active_bank),
`ifdef WP_FAULT_EN
    .fault           (fault),
    .fault_addr      (fault_addr),
    .fault_clr       (fault_clr),
`endif
    .ram_disable     (ram_disable),
    .rom_disable     (rom_disable)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic tbl_write(input logic [1:0] b, input logic [8:0] a, input logic [1:0] v);
    table_we = 1'b1; table_bank = b; table_write_addr = a; table_val = v;
    step();
    table_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; table_we = 0; table_bank = 0; table_write_addr = 0; table_val = 0;
    clear_req = 0; bank_req = 0; bank_sel = 0; ram_disable = 0; rom_disable = 0;
    cpu_bus.address = 16'h0000; cpu_bus.phi2 = 0; cpu_bus.rwbar = 1; cpu_bus.mreq = 0;
`ifdef WP_FAULT_EN
    fault_clr = 0;
`endif
    repeat (3) step();
    n_cmp++; if (table_rdy !== 1'b0) begin n_err++; $display("FAIL reset_table_rdy: got %b expected 0", table_rdy); end
    n_cmp++; if (cpu_bus.cs_ram !== 1'b0) begin n_err++; $display("FAIL reset_cs_ram: got %b expected 0", cpu_bus.cs_ram); end
    n_cmp++; if (cpu_bus.cs_bus !== 1'b1) begin n_err++; $display("FAIL reset_cs_bus: got %b expected 1", cpu_bus.cs_bus); end
    n_cmp++; if (active_bank !== 2'd0) begin n_err++; $display("FAIL reset_active_bank: got %0d expected 0", active_bank); end
    n_cmp++; if (bank_ack !== 1'b0) begin n_err++; $display("FAIL reset_bank_ack: got %b expected 0", bank_ack); end
    n_cmp++; if (cpu_bus.we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", cpu_bus.we); end
`ifdef WP_FAULT_EN
    n_cmp++; if (fault !== 1'b0 || fault_addr !== 16'h0000) begin n_err++; $display("FAIL reset_fault: got %b/%h expected 0/0000", fault, fault_addr); end
`endif
  endtask

  task automatic test_initial_clear();
    int n = 0;
    rst_n = 1'b1;
    cpu_bus.mreq = 1; cpu_bus.phi2 = 0; cpu_bus.rwbar = 1; cpu_bus.address = 16'h8012;
    while (table_rdy !== 1'b1 && n < 3000) begin
      step();
      n++;
      if (n == 10) begin
        n_cmp++; if (cpu_bus.cs_bus !== 1'b0 || cpu_bus.cs_ram !== 1'b0) begin n_err++; $display("FAIL clear_passthru_phi2_low: got cs_bus=%b cs_ram=%b expected 0/0", cpu_bus.cs_bus, cpu_bus.cs_ram); end
        cpu_bus.phi2 = 1;
      end
      if (n == 11) begin
        n_cmp++; if (cpu_bus.cs_bus !== 1'b1 || cpu_bus.cs_ram !== 1'b0 || table_rdy !== 1'b0) begin n_err++; $display("FAIL clear_passthru_phi2_high: got cs_bus=%b cs_ram=%b rdy=%b expected 1/0/0", cpu_bus.cs_bus, cpu_bus.cs_ram, table_rdy); end
      end
    end
    n_cmp++; if (n != 2048) begin n_err++; $display("FAIL reset_clear_cycles: got %0d expected 2048", n); end
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b1) begin n_err++; $display("FAIL cleared_lookup: got cs_ram=%b cs_bus=%b expected 0/1", cpu_bus.cs_ram, cpu_bus.cs_bus); end
  endtask

  task automatic test_load_lookup();
    cpu_bus.phi2 = 0; cpu_bus.address = 16'h0000; cpu_bus.rwbar = 1; cpu_bus.mreq = 1;
    tbl_write(2'd0, 9'h180, 2'b10);
    tbl_write(2'd0, 9'h080, 2'b10);
    step();
    cpu_bus.address = 16'h8012; cpu_bus.phi2 = 1;
    #1;
    n_cmp++; if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b1) begin n_err++; $display("FAIL lookup_latency: got cs_ram=%b cs_bus=%b expected 0/1", cpu_bus.cs_ram, cpu_bus.cs_bus); end
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b1 || cpu_bus.cs_bus !== 1'b0) begin n_err++; $display("FAIL lookup_read_ram: got cs_ram=%b cs_bus=%b expected 1/0", cpu_bus.cs_ram, cpu_bus.cs_bus); end
    n_cmp++; if (cpu_bus.we !== 1'b0) begin n_err++; $display("FAIL we_read: got %b expected 0", cpu_bus.we); end
    cpu_bus.rwbar = 0;
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b1 || cpu_bus.we !== 1'b1) begin n_err++; $display("FAIL lookup_write_ram: got cs_ram=%b we=%b expected 1/1", cpu_bus.cs_ram, cpu_bus.we); end
    cpu_bus.rwbar = 1;
    step();
  endtask

  task automatic test_disable();
    ram_disable = 1;
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b1) begin n_err++; $display("FAIL ram_disable: got cs_ram=%b cs_bus=%b expected 0/1", cpu_bus.cs_ram, cpu_bus.cs_bus); end
    ram_disable = 0;
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b1) begin n_err++; $display("FAIL ram_disable_release: got %b expected 1", cpu_bus.cs_ram); end
    tbl_write(2'd0, 9'h080, 2'b01);
    rom_disable = 1;
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b1) begin n_err++; $display("FAIL rom_disable: got cs_ram=%b cs_bus=%b expected 0/1", cpu_bus.cs_ram, cpu_bus.cs_bus); end
    rom_disable = 0; ram_disable = 1;
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b1 || cpu_bus.cs_bus !== 1'b0) begin n_err++; $display("FAIL ram_disable_on_rom_region: got cs_ram=%b cs_bus=%b expected 1/0", cpu_bus.cs_ram, cpu_bus.cs_bus); end
    ram_disable = 0;
    step();
  endtask

  task automatic test_same_cycle_write();
    tbl_write(2'd0, 9'h180, 2'b00);
    n_cmp++; if (cpu_bus.cs_ram !== 1'b1) begin n_err++; $display("FAIL same_edge_old_value: got cs_ram=%b expected 1", cpu_bus.cs_ram); end
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b0) begin n_err++; $display("FAIL same_edge_new_value: got cs_ram=%b cs_bus=%b expected 0/0", cpu_bus.cs_ram, cpu_bus.cs_bus); end
    tbl_write(2'd0, 9'h180, 2'b10);
    step();
  endtask

  task automatic test_bank_switch();
    cpu_bus.phi2 = 1; bank_sel = 2; bank_req = 1;
    step();
    bank_req = 0;
    n_cmp++; if (active_bank !== 2'd0 || bank_ack !== 1'b0) begin n_err++; $display("FAIL bank_hold_phi2_high: got bank=%0d ack=%b expected 0/0", active_bank, bank_ack); end
    step(); step();
    n_cmp++; if (active_bank !== 2'd0) begin n_err++; $display("FAIL bank_hold_phi2_high2: got %0d expected 0", active_bank); end
    cpu_bus.phi2 = 0;
    step();
    n_cmp++; if (active_bank !== 2'd2 || bank_ack !== 1'b1) begin n_err++; $display("FAIL bank_apply: got bank=%0d ack=%b expected 2/1", active_bank, bank_ack); end
    step();
    n_cmp++; if (active_bank !== 2'd2 || bank_ack !== 1'b0) begin n_err++; $display("FAIL bank_ack_pulse: got bank=%0d ack=%b expected 2/0", active_bank, bank_ack); end
    cpu_bus.phi2 = 1;
    step();
    n_cmp++; if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b1) begin n_err++; $display("FAIL bank2_lookup: got cs_ram=%b cs_bus=%b expected 0/1", cpu_bus.cs_ram, cpu_bus.cs_bus); end
    bank_req = 1; bank_sel = 3;
    step();
    bank_sel = 1;
    step();
    bank_req = 0; cpu_bus.phi2 = 0;
    step();
    n_cmp++; if (active_bank !== 2'd1 || bank_ack !== 1'b1) begin n_err++; $display("FAIL bank_last_wins: got bank=%0d ack=%b expected 1/1", active_bank, bank_ack); end
    bank_req = 1; bank_sel = 3;
    step();
    n_cmp++; if (active_bank !== 2'd1 || bank_ack !== 1'b0) begin n_err++; $display("FAIL bank_req_latch: got bank=%0d ack=%b expected 1/0", active_bank, bank_ack); end
    bank_sel = 0;
    step();
    bank_req = 0;
    n_cmp++; if (active_bank !== 2'd3 || bank_ack !== 1'b1) begin n_err++; $display("FAIL bank_apply_with_req: got bank=%0d ack=%b expected 3/1", active_bank, bank_ack); end
    step();
    n_cmp++; if (active_bank !== 2'd0 || bank_ack !== 1'b1) begin n_err++; $display("FAIL bank_back_to_back: got bank=%0d ack=%b expected 0/1", active_bank, bank_ack); end
    step();
  endtask

  task automatic test_clear_mid_load();
    int n = 0;
    int bad = 0;
    cpu_bus.phi2 = 0;
    for (int i = 0; i < 5; i++) begin
      tbl_write(2'd1, 9'h110 + 9'(i), 2'b10);
    end
    clear_req = 1;
    step();
    clear_req = 0;
    n_cmp++; if (table_rdy !== 1'b0) begin n_err++; $display("FAIL clear_req_rdy: got %b expected 0", table_rdy); end
    table_bank = 2'd0; table_write_addr = 9'h180; table_val = 2'b10;
    while (table_rdy !== 1'b1 && n < 3000) begin
      table_we = (n == 1000);
      step();
      n++;
    end
    table_we = 0;
    n_cmp++; if (n != 2048) begin n_err++; $display("FAIL clear_req_cycles: got %0d expected 2048", n); end
    cpu_bus.phi2 = 1; cpu_bus.mreq = 1; cpu_bus.rwbar = 1;
    for (int r = 0; r < 256; r++) begin
      cpu_bus.address = {r[7:0], 8'h00};
      step();
      if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL cleared_bank0_regions: got %0d bad regions expected 0", bad); end
    cpu_bus.phi2 = 0; bank_req = 1; bank_sel = 1;
    step();
    bank_req = 0;
    step();
    cpu_bus.phi2 = 1; bad = 0;
    for (int r = 16; r < 21; r++) begin
      cpu_bus.address = {r[7:0], 8'h34};
      step();
      if (cpu_bus.cs_ram !== 1'b0 || cpu_bus.cs_bus !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL cleared_bank1_loaded: got %0d bad regions expected 0", bad); end
    cpu_bus.phi2 = 0; bank_req = 1; bank_sel = 0;
    step();
    bank_req = 0;
    step();
    n_cmp++; if (active_bank !== 2'd0) begin n_err++; $display("FAIL bank_restore: got %0d expected 0", active_bank); end
  endtask

`ifdef WP_FAULT_EN
  task automatic test_fault();
    cpu_bus.phi2 = 0;
    tbl_write(2'd0, 9'h0C0, 2'b00);
    cpu_bus.address = 16'hC000; cpu_bus.rwbar = 0; cpu_bus.mreq = 1; cpu_bus.phi2 = 1;
    step();
    n_cmp++; if (fault !== 1'b1 || fault_addr !== 16'hC000) begin n_err++; $display("FAIL fault_set: got %b/%h expected 1/c000", fault, fault_addr); end
    cpu_bus.address = 16'hC055;
    step();
    n_cmp++; if (fault !== 1'b1 || fault_addr !== 16'hC000) begin n_err++; $display("FAIL fault_sticky: got %b/%h expected 1/c000", fault, fault_addr); end
    cpu_bus.phi2 = 0; fault_clr = 1;
    step();
    fault_clr = 0;
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clr: got %b expected 0", fault); end
    cpu_bus.address = 16'h1234; cpu_bus.phi2 = 1;
    step();
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_unprotected: got %b expected 0", fault); end
    cpu_bus.address = 16'hC0AA;
    step();
    cpu_bus.address = 16'hC011; fault_clr = 1;
    step();
    fault_clr = 0;
    n_cmp++; if (fault !== 1'b1 || fault_addr !== 16'hC011) begin n_err++; $display("FAIL fault_clr_and_new: got %b/%h expected 1/c011", fault, fault_addr); end
    cpu_bus.phi2 = 0; cpu_bus.rwbar = 1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_initial_clear();
    test_load_lookup();
    test_disable();
    test_same_cycle_write();
    test_bank_switch();
    test_clear_mid_load();
`ifdef WP_FAULT_EN
    test_fault();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
